nx_fifo_stream_reader: RTL and testbench

//   Read-side drain engine for the nx_fifo family. Pops a FIFO through its
//   ren/empty/rdata read port, whose head word is combinationally visible

---
 rtl/nx_fifo_stream_reader.sv | 109 ++++++++++
 tb/tb_nx_fifo_stream_reader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/nx_fifo_stream_reader.sv
// nx_fifo_stream_reader: drains a FIFO read port (show-ahead rdata, ren/empty) into a
// registered valid/ready stream via a 2-entry head+skid buffer; latency 1 cycle min.
// Backpressure: out_ready_i stalls the buffer; fifo_ren_o depends only on state, flag, clear, rst.
//
// Ports:
//   clk_i, rst_i (sync, active high), clear_i (flush buffered words)
//   fifo_empty_i, fifo_rdata_i, fifo_ren_o   FIFO read port
//   out_valid_o, out_ready_i, out_data_o      output stream (data masked to 0 when idle)
//   occupancy_o (0..2 buffered words), beat_cnt_o (saturating accepted-beat count)
module nx_fifo_stream_reader #(
  parameter int WIDTH      = 128,
  parameter int CNT_W      = 32,
  parameter bit DATA_RESET = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             fifo_empty_i,
  input  logic [WIDTH-1:0] fifo_rdata_i,
  output logic             fifo_ren_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [1:0]       occupancy_o,
  output logic [CNT_W-1:0] beat_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] skid_q;
  logic [CNT_W-1:0] beat_cnt_q;
  logic [CNT_W-1:0] beat_cnt_d;
  logic             push;
  logic             pop;

  // Pop strobe looks only at registered state and the empty flag, never at
  // out_ready_i, so the FIFO read path has no combinational dependency on
  // the downstream consumer.
  assign fifo_ren_o  = !fifo_empty_i && (state_q != TWO) && !clear_i && !rst_i;
  assign push        = fifo_ren_o;
  assign out_valid_o = (state_q != EMPTY);
  assign pop         = out_valid_o && out_ready_i;
  assign out_data_o  = out_valid_o ? head_q : '0;
  assign occupancy_o = state_q;
  assign beat_cnt_o  = beat_cnt_q;

  // Saturating: stick at all-ones rather than wrap.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (pop && (beat_cnt_q != {CNT_W{1'b1}})) begin
      beat_cnt_d = beat_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= EMPTY;
      beat_cnt_q <= '0;
      if (DATA_RESET) begin
        head_q <= '0;
        skid_q <= '0;
      end
    end else begin
      // A pop coinciding with clear is still a delivered beat.
      beat_cnt_q <= beat_cnt_d;
      if (clear_i) begin
        state_q <= EMPTY;
        if (DATA_RESET) begin
          head_q <= '0;
          skid_q <= '0;
        end
      end else begin
        unique case (state_q)
          EMPTY: begin
            if (push) begin
              head_q  <= fifo_rdata_i;
              state_q <= ONE;
            end
          end
          ONE: begin
            if (push && pop) begin
              head_q <= fifo_rdata_i;
            end else if (push) begin
              skid_q  <= fifo_rdata_i;
              state_q <= TWO;
            end else if (pop) begin
              state_q <= EMPTY;
            end
          end
          TWO: begin
            // Full: push is impossible here, only drain into head.
            if (pop) begin
              head_q  <= skid_q;
              state_q <= ONE;
            end
          end
          default: state_q <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nx_fifo_stream_reader.sv
// tb_nx_fifo_stream_reader: randomized scoreboard bench for nx_fifo_stream_reader.
// The FIFO is a queue; every word written to it is also appended to the expected
// stream, and a monitor pops/compares on each accepted output beat.
module tb_nx_fifo_stream_reader;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;
  localparam int SAT   = 15;

  logic             clk;
  logic             rst;
  logic             clear;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_rdata;
  logic             fifo_ren;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] beat_cnt;

  nx_fifo_stream_reader #(
    .WIDTH     (WIDTH),
    .CNT_W     (CNT_W),
    .DATA_RESET(1'b1)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_i     (clear),
    .fifo_empty_i(fifo_empty),
    .fifo_rdata_i(fifo_rdata),
    .fifo_ren_o  (fifo_ren),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .occupancy_o (occupancy),
    .beat_cnt_o  (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [WIDTH-1:0] tbfifo[$];   // contents of the attached FIFO
  logic [WIDTH-1:0] exp_q[$];    // words owed to the consumer, oldest first
  int               in_dut = 0;  // words taken from the FIFO but not yet delivered
  int               delivered = 0;
  bit               ren_seen = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic refresh();
    fifo_empty = (tbfifo.size() == 0);
    fifo_rdata = fifo_empty ? '0 : tbfifo[0];
  endtask

  task automatic tick();
    logic [WIDTH-1:0] junk;
    @(posedge clk);
    #1;
    if (ren_seen && tbfifo.size() > 0) junk = tbfifo.pop_front();
    refresh();
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w);
    tbfifo.push_back(w);
    exp_q.push_back(w);
    refresh();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Monitor: reference model of the buffer is a plain count of words in
  // flight plus the expected-word queue.
  initial begin : monitor
    bit               hold_prev = 1'b0;
    logic [WIDTH-1:0] data_prev = '0;
    logic [WIDTH-1:0] junk;
    logic [WIDTH-1:0] want;
    bit               ren_exp;
    forever begin
      @(negedge clk);
      ren_exp = !fifo_empty && (in_dut < 2) && !clear && !rst;
      chk("occupancy", occupancy, in_dut);
      chk("out_valid", out_valid, (in_dut != 0));
      chk("beat_cnt", beat_cnt, (delivered > SAT) ? SAT : delivered);
      chk("fifo_ren", fifo_ren, ren_exp);
      if (!out_valid) chk("data_mask", out_data, 0);
      if (hold_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, data_prev);
      end
      hold_prev = out_valid && !out_ready && !clear && !rst;
      data_prev = out_data;
      ren_seen  = fifo_ren;
      if (rst) begin
        repeat (in_dut) if (exp_q.size() > 0) junk = exp_q.pop_front();
        in_dut    = 0;
        delivered = 0;
      end else begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", out_data, 0);
            n_err++;
            $display("FAIL stream: beat 0x%0h delivered with nothing expected", out_data);
          end else begin
            want = exp_q.pop_front();
            chk("stream_data", out_data, want);
          end
          if (in_dut > 0) in_dut--;
          delivered++;
        end
        if (clear) begin
          repeat (in_dut) if (exp_q.size() > 0) junk = exp_q.pop_front();
          in_dut = 0;
        end else if (ren_exp) begin
          in_dut++;
        end
      end
    end
  end

  initial begin : driver
    rst       = 1'b1;
    clear     = 1'b0;
    out_ready = 1'b0;
    refresh();

    // Reset with a non-empty FIFO: nothing may be popped or presented.
    push_word(32'h0000_00A5);
    tick(); tick(); tick();
    chk("rst_ren", fifo_ren, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_beat", beat_cnt, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();

    // Streaming 1,2,3 with ready held high.
    do_reset();
    push_word(32'h1); push_word(32'h2); push_word(32'h3);
    repeat (6) tick();
    chk("stream_beats", beat_cnt, 3);

    // Backpressure: buffer fills to two and holds the head word.
    do_reset();
    out_ready = 1'b0;
    push_word(32'h1); push_word(32'h2); push_word(32'h3);
    repeat (5) tick();
    chk("bp_occ", occupancy, 2);
    chk("bp_ren", fifo_ren, 0);
    chk("bp_data", out_data, 32'h1);
    out_ready = 1'b1;
    repeat (5) tick();

    // Alternating ready over 16 random words.
    for (int i = 0; i < 16; i++) push_word($urandom);
    for (int i = 0; i < 40; i++) begin
      out_ready = (i % 2 == 0);
      tick();
    end
    out_ready = 1'b1;
    repeat (20) tick();

    // Clear at full occupancy, then the remaining FIFO words resume.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(32'hC000_0000 + i);
    repeat (4) tick();
    chk("pre_clear_occ", occupancy, 2);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_occ", occupancy, 0);
    chk("clear_valid", out_valid, 0);
    out_ready = 1'b1;
    repeat (6) tick();

    // Saturation of the 4-bit beat counter.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) push_word(32'h5A00_0000 + i);
    repeat (25) tick();
    chk("beat_sat", beat_cnt, SAT);

    // Random mix of pushes, ready and occasional clear.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(2) == 0) push_word($urandom);
      out_ready = $urandom_range(1);
      clear     = ($urandom_range(39) == 0);
      tick();
    end
    clear     = 1'b0;
    out_ready = 1'b1;

    // Bounded drain: everything owed must come out.
    for (int i = 0; i < 400 && (exp_q.size() != 0 || in_dut != 0); i++) tick();
    chk("drain_left", exp_q.size(), 0);
    chk("drain_occ", occupancy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
